// File: rtl/text_char_buffer_pkg.sv
// Shared state encoding and ASCII constants for the text character buffer.
package text_buf_pkg;

    typedef enum logic [1:0] {
        StClearAll,
        StIdle,
        StClearLine
    } state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] PRINT_LO    = 8'h20;
    localparam logic [7:0] PRINT_HI    = 8'h7E;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= PRINT_LO) && (c <= PRINT_HI);
    endfunction

endpackage

// File: rtl/text_char_buffer_if.sv
// Valid/ready character stream from the ASCII generator stage into the text buffer.
interface text_char_buffer_if;

    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;

    modport master (
        output char_in,
        output char_valid,
        input  char_ready
    );

    modport slave (
        input  char_in,
        input  char_valid,
        output char_ready
    );

endinterface

// File: rtl/text_char_buffer_ram.sv
// Simple dual-port character RAM: one write port, one registered read port.
module text_char_ram #(
    parameter int unsigned Depth = 2400,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [7:0]       wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [7:0]       rdata_o
);

    logic [7:0] mem_q [Depth];

    // Read and write share one edge; a colliding read returns the pre-write contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/text_char_buffer.sv
// COLS x ROWS text screen: consumes an ASCII stream, tracks the cursor, blanks lines on advance.
module text_char_buffer
    import text_buf_pkg::*;
#(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 30,
    localparam int unsigned ADDR_W = $clog2(COLS * ROWS),
    localparam int unsigned COL_W  = $clog2(COLS),
    localparam int unsigned ROW_W  = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              reset,
    text_char_buffer_if.slave chr,
    input  logic              clear_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row,
    output logic [15:0]       char_count
);

    localparam logic [ADDR_W-1:0] LastPtr     = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LastLinePtr = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ColsA       = ADDR_W'(COLS);
    localparam logic [COL_W-1:0]  ColMax      = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  RowMax      = ROW_W'(ROWS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [15:0]         count_q, count_d;

    logic                char_ready;
    logic                xfer;
    logic                advance;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [7:0]          ram_wdata;
    logic [ADDR_W-1:0]   row_base;
    logic [ADDR_W-1:0]   cur_addr;

    assign xfer     = chr.char_valid && char_ready;
    assign row_base = ADDR_W'(row_q) * ColsA;
    assign cur_addr = row_base + ADDR_W'(col_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StClearAll;
            ptr_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        col_d   = col_q;
        row_d   = row_q;
        count_d = count_q;
        advance = 1'b0;
        unique case (state_q)
            StClearAll: begin
                col_d = '0;
                row_d = '0;
                if (ptr_q == LastPtr) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            StClearLine: begin
                if (ptr_q == LastLinePtr) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            StIdle: begin
                if (clear_req) begin
                    state_d = StClearAll;
                    ptr_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                    count_d = '0;
                end else if (xfer) begin
                    if (is_printable(chr.char_in)) begin
                        if (count_q != 16'hFFFF) begin
                            count_d = count_q + 16'd1;
                        end
                        if (col_q == ColMax) begin
                            col_d   = '0;
                            advance = 1'b1;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end else if (chr.char_in == ASCII_LF) begin
                        col_d   = '0;
                        advance = 1'b1;
                    end else if (chr.char_in == ASCII_CR) begin
                        col_d = '0;
                    end else if (chr.char_in == ASCII_BS && col_q != '0) begin
                        col_d = col_q - COL_W'(1);
                    end
                    // No scrolling: the row wraps and the new line is blanked before more input.
                    if (advance) begin
                        row_d   = (row_q == RowMax) ? '0 : row_q + ROW_W'(1);
                        state_d = StClearLine;
                        ptr_d   = '0;
                    end
                end
            end
            default: begin
                state_d = StClearAll;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        char_ready = (state_q == StIdle) && !clear_req;
        ram_we     = 1'b0;
        ram_waddr  = '0;
        ram_wdata  = ASCII_SPACE;
        unique case (state_q)
            StClearAll: begin
                ram_we    = 1'b1;
                ram_waddr = ptr_q;
            end
            StClearLine: begin
                ram_we    = 1'b1;
                ram_waddr = row_base + ptr_q;
            end
            StIdle: begin
                if (xfer) begin
                    if (is_printable(chr.char_in)) begin
                        ram_we    = 1'b1;
                        ram_waddr = cur_addr;
                        ram_wdata = chr.char_in;
                    end else if (chr.char_in == ASCII_BS && col_q != '0) begin
                        ram_we    = 1'b1;
                        ram_waddr = cur_addr - ADDR_W'(1);
                    end
                end
            end
            default: ;
        endcase
        ram_we = ram_we && !reset;
    end

    assign chr.char_ready = char_ready;
    assign cursor_col     = col_q;
    assign cursor_row     = row_q;
    assign char_count     = count_q;

    text_char_ram #(
        .Depth (COLS * ROWS),
        .AddrW (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_text_char_buffer.sv
// Directed bench for text_char_buffer on an 8x4 screen.
module tb_text_char_buffer;

    localparam int unsigned COLS = 8;
    localparam int unsigned ROWS = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear_req;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [2:0] cursor_col;
    logic [1:0] cursor_row;
    logic [15:0] char_count;

    int total = 0;
    int bad   = 0;

    text_char_buffer_if cif ();

    text_char_buffer #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chr        (cif),
        .clear_req  (clear_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .char_count (char_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a, output logic [7:0] d);
        rd_addr = a[4:0];
        step();
        d = rd_data;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (cif.char_ready !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
    endtask

    task automatic send(input logic [7:0] c);
        int n;
        wait_ready(n);
        chk("send_timeout", 32'(n >= 1000), 0);
        cif.char_in    = c;
        cif.char_valid = 1'b1;
        step();
        cif.char_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [7:0] d;

        cif.char_in    = 8'h00;
        cif.char_valid = 1'b0;
        clear_req      = 1'b0;
        rd_addr        = '0;
        reset          = 1'b1;
        step();
        step();
        chk("rst_ready", 32'(cif.char_ready), 0);
        chk("rst_col", 32'(cursor_col), 0);
        chk("rst_row", 32'(cursor_row), 0);
        chk("rst_count", 32'(char_count), 0);
        reset = 1'b0;

        wait_ready(n);
        chk("clear_all_cycles", n, 32);
        chk("init_col", 32'(cursor_col), 0);
        chk("init_row", 32'(cursor_row), 0);
        chk("init_count", 32'(char_count), 0);
        for (int a = 0; a < 32; a++) begin
            rd(a, d);
            chk("init_blank", 32'(d), 32'h20);
        end

        // Eight printable characters back to back with valid held high.
        cif.char_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cif.char_in = 8'(8'h61 + i);
            chk("stream_ready", 32'(cif.char_ready), 1);
            step();
        end
        cif.char_valid = 1'b0;
        chk("stream_col", 32'(cursor_col), 0);
        chk("stream_row", 32'(cursor_row), 1);
        chk("stream_count", 32'(char_count), 8);
        wait_ready(n);
        chk("line_clear_cycles", n, 8);
        for (int i = 0; i < 8; i++) begin
            rd(i, d);
            chk("stream_mem", 32'(d), 32'(8'h61 + i));
        end

        // LF from row 1 down to row 3 and wrap back to row 0.
        send(8'h0A);
        chk("lf_row2", 32'(cursor_row), 2);
        send(8'h0A);
        chk("lf_row3", 32'(cursor_row), 3);
        send(8'h0A);
        wait_ready(n);
        chk("wrap_clear_cycles", n, 8);
        chk("wrap_col", 32'(cursor_col), 0);
        chk("wrap_row", 32'(cursor_row), 0);
        for (int i = 0; i < 8; i++) begin
            rd(i, d);
            chk("wrap_row0_blank", 32'(d), 32'h20);
        end

        // Backspace handling.
        send(8'h41);
        send(8'h42);
        send(8'h43);
        chk("bs_pre_col", 32'(cursor_col), 3);
        chk("bs_pre_count", 32'(char_count), 11);
        send(8'h08);
        chk("bs_col", 32'(cursor_col), 2);
        chk("bs_count", 32'(char_count), 11);
        rd(2, d);
        chk("bs_erase", 32'(d), 32'h20);
        rd(1, d);
        chk("bs_keep", 32'(d), 32'h42);
        send(8'h08);
        send(8'h08);
        chk("bs_col0", 32'(cursor_col), 0);
        rd(0, d);
        chk("bs_erase0", 32'(d), 32'h20);
        send(8'h08);
        chk("bs_noop_col", 32'(cursor_col), 0);
        chk("bs_noop_row", 32'(cursor_row), 0);
        chk("bs_noop_count", 32'(char_count), 11);

        // clear_req beats a simultaneous character.
        send(8'h5A);
        rd(0, d);
        chk("pre_clear_mem", 32'(d), 32'h5A);
        cif.char_in    = 8'h41;
        cif.char_valid = 1'b1;
        clear_req      = 1'b1;
        #1;
        chk("clear_ready", 32'(cif.char_ready), 0);
        step();
        clear_req      = 1'b0;
        cif.char_valid = 1'b0;
        wait_ready(n);
        chk("clear_cycles", n, 32);
        chk("clear_count", 32'(char_count), 0);
        chk("clear_col", 32'(cursor_col), 0);
        chk("clear_row", 32'(cursor_row), 0);
        rd(0, d);
        chk("clear_mem0", 32'(d), 32'h20);

        // Non-printable, non-control codes are consumed without effect.
        send(8'h51);
        for (int i = 0; i < 3; i++) begin
            wait_ready(n);
            chk("other_ready", n, 0);
            cif.char_in    = (i == 0) ? 8'h07 : (i == 1) ? 8'h7F : 8'hC0;
            cif.char_valid = 1'b1;
            step();
            cif.char_valid = 1'b0;
        end
        chk("other_col", 32'(cursor_col), 1);
        chk("other_row", 32'(cursor_row), 0);
        chk("other_count", 32'(char_count), 1);
        rd(1, d);
        chk("other_mem1", 32'(d), 32'h20);
        rd(0, d);
        chk("other_mem0", 32'(d), 32'h51);

        // CR homes the column without writing.
        send(8'h0D);
        chk("cr_col", 32'(cursor_col), 0);
        chk("cr_row", 32'(cursor_row), 0);
        chk("cr_count", 32'(char_count), 1);
        rd(0, d);
        chk("cr_mem0", 32'(d), 32'h51);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/text_char_buffer.md
Name: text_char_buffer

Overview:
- Downstream consumer of the ASCII character generator stage. Accepts a stream of 8-bit ASCII codes over a valid/ready handshake and maintains a COLS x ROWS text screen in an internal character RAM.
- Tracks a cursor and interprets a small set of control codes.
- Exposes a synchronous read port for the VGA text renderer, plus cursor and character-count status for debug display.

Parameters:
- COLS, 80, characters per row
- ROWS, 30, rows per screen
- ADDR_W, $clog2(COLS*ROWS), RAM address width (derived; do not override)

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- char_in  in  8  ASCII code from the generator stage
- char_valid  in  1  char_in is valid this cycle
- char_ready  out  1  block accepts char_in this cycle
- clear_req  in  1  one-cycle request to blank the screen and home the cursor
- rd_addr  in  ADDR_W  renderer read address, row*COLS+col
- rd_data  out  8  character at rd_addr, one cycle later
- cursor_col  out  $clog2(COLS)  current cursor column
- cursor_row  out  $clog2(ROWS)  current cursor row
- char_count  out  16  printable characters written since last clear; saturating

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- States: CLEAR_ALL, IDLE, CLEAR_LINE.
- Reset:
  - Enter CLEAR_ALL with clear pointer 0.
  - cursor_col=0, cursor_row=0, char_count=0, char_ready=0.
  - rd_data is not defined until the first read after reset.
- char_ready = (state==IDLE) && !clear_req. This is combinational from the state register and clear_req.
- Transfer occurs when char_valid && char_ready. Exactly one character is consumed per transfer.
- CLEAR_ALL:
  - Writes 0x20 to address ptr each cycle; ptr increments 0..COLS*ROWS-1.
  - Takes exactly COLS*ROWS cycles, then goes to IDLE.
  - Cursor is held at (0,0).
- CLEAR_LINE:
  - Writes 0x20 to row cursor_row, cols 0..COLS-1, one per cycle.
  - Takes exactly COLS cycles, then goes to IDLE.
- IDLE, clear_req=1:
  - Go to CLEAR_ALL, cursor to (0,0), char_count=0.
  - clear_req takes priority over a simultaneous char_valid; that character is not accepted.
- IDLE, accepted character:
  - 0x20..0x7E (printable): write to (row,col); char_count += 1, saturating at 0xFFFF.
    - If col<COLS-1: col += 1.
    - Otherwise: col=0 and advance row.
  - 0x0A (LF): col=0, advance row.
  - 0x0D (CR): col=0, row unchanged, no write.
  - 0x08 (BS):
    - If col>0: col -= 1 and write 0x20 at (row,col-1).
    - If col==0: no-op; no wrap to the previous row.
    - char_count is not decremented.
  - Any other code (0x00..0x1F except above, 0x7F..0xFF): consumed, no effect.
- Advance row:
  - row = (row==ROWS-1) ? 0 : row+1.
  - Then enter CLEAR_LINE for the new row. There is no scrolling; the new line is always blanked before further input.
- clear_req during CLEAR_ALL or CLEAR_LINE is ignored (not latched).
- Read port:
  - Synchronous, latency 1 cycle.
  - Independent of state; the renderer may read during clears.
  - Read and write to the same address in the same cycle return the old data.
- Reset asserted mid-clear or mid-transfer restarts CLEAR_ALL from ptr 0.

Decomposition:
- Package text_buf_pkg:
  - state enum (CLEAR_ALL, IDLE, CLEAR_LINE)
  - constants ASCII_SPACE=8'h20, ASCII_LF=8'h0A, ASCII_CR=8'h0D, ASCII_BS=8'h08, PRINT_LO=8'h20, PRINT_HI=8'h7E
- Sub-module text_char_ram:
  - simple dual-port RAM, depth COLS*ROWS, 8-bit
  - one write port, one synchronous read port, read-old-on-collision
  - written so it infers block RAM
- Cursor/state logic stays in text_char_buffer.

Test Plan (COLS=8, ROWS=4):
- Reset for 2 cycles, then release.
  - char_ready stays 0 for exactly 32 cycles, then 1.
  - Reading all 32 addresses returns 0x20.
  - Cursor (0,0), char_count=0.
- Stream 0x61..0x68 with char_valid held high.
  - mem[0..7]=0x61..0x68; cursor (0,1); char_count=8.
  - char_ready is low for exactly 8 cycles after the 8th transfer (line clear of row 1).
- Send LF in each row until row 3, then LF again.
  - Cursor wraps to (0,0).
  - Row 0 reads all 0x20 after the 8-cycle CLEAR_LINE.
- From col 3, send BS.
  - Cursor col=2, mem[row*8+2]=0x20, char_count unchanged.
  - A second BS sequence down to col 0, then one more BS: no change, no write.
- Assert clear_req in the same cycle as char_valid with char_in=0x41.
  - char_ready=0, so 0x41 is not written.
  - 32-cycle CLEAR_ALL runs; char_count=0; cursor (0,0).
- Send 0x07, 0x7F and 0xC0.
  - Each is accepted (one handshake each).
  - No RAM writes, cursor unchanged, char_count unchanged.
